// File: rtl/ranging_burst_generator.sv
// Tone-burst transmitter for the acoustic ranging loop: shaped burst on trigger,
// one sample per audio step, then a silent guard interval before re-arming.
module ranging_burst_generator #(
    parameter int                 BURST_SAMPLES = 48,
    parameter int                 HALF_PERIOD   = 2,
    parameter logic signed [15:0] AMPLITUDE     = 16'sd12000,
    parameter int                 RAMP_LOG2     = 3,
    parameter int                 GUARD_SAMPLES = 32
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        step_in,
    input  logic        trigger_in,
    input  logic        abort_in,
    output logic [15:0] amp_out,
    output logic        start_out,
    output logic        busy_out,
    output logic        done_out
);

    localparam int RAMP = 1 << RAMP_LOG2;
    localparam int PW   = 16 + RAMP_LOG2 + 1;
    localparam int KW   = $clog2(BURST_SAMPLES + 1);
    localparam int HW   = (HALF_PERIOD > 1) ? $clog2(HALF_PERIOD) : 1;
    localparam int GW   = (GUARD_SAMPLES > 1) ? $clog2(GUARD_SAMPLES) : 1;

    typedef enum logic [1:0] {IDLE, ARMED, BURST, GUARD} state_t;

    state_t          state_reg;
    logic [KW-1:0]   k_reg;
    logic [HW-1:0]   hp_reg;
    logic            neg_reg;
    logic [GW-1:0]   g_reg;

    int              env_int;
    logic [PW-1:0]   prod;
    logic [15:0]     mag;
    logic [15:0]     sample_val;

    assign busy_out = (state_reg != IDLE);

    // Sample for index k_reg; the tone sign is tracked by hp_reg/neg_reg
    // alongside k_reg so no divider is needed.
    always_comb begin
        env_int = RAMP;
        if (int'(k_reg) + 1 < env_int)
            env_int = int'(k_reg) + 1;
        if (BURST_SAMPLES - int'(k_reg) < env_int)
            env_int = BURST_SAMPLES - int'(k_reg);
        prod       = $unsigned(PW'(AMPLITUDE)) * $unsigned(PW'(env_int));
        mag        = 16'(prod >> RAMP_LOG2);
        sample_val = neg_reg ? (~mag + 16'd1) : mag;
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state_reg <= IDLE;
            amp_out   <= '0;
            start_out <= 1'b0;
            done_out  <= 1'b0;
            k_reg     <= '0;
            hp_reg    <= '0;
            neg_reg   <= 1'b0;
            g_reg     <= '0;
        end else begin
            start_out <= 1'b0;
            done_out  <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (trigger_in && !abort_in) begin
                        state_reg <= ARMED;
                        k_reg     <= '0;
                        hp_reg    <= '0;
                        neg_reg   <= 1'b0;
                    end
                end
                ARMED, BURST: begin
                    if (abort_in) begin
                        amp_out   <= '0;
                        g_reg     <= '0;
                        state_reg <= GUARD;
                    end else if (step_in) begin
                        if (k_reg < KW'(BURST_SAMPLES)) begin
                            amp_out   <= sample_val;
                            start_out <= (state_reg == ARMED);
                            state_reg <= BURST;
                            k_reg     <= k_reg + 1'b1;
                            if (hp_reg == HW'(HALF_PERIOD - 1)) begin
                                hp_reg  <= '0;
                                neg_reg <= ~neg_reg;
                            end else begin
                                hp_reg  <= hp_reg + 1'b1;
                            end
                        end else begin
                            amp_out   <= '0;
                            g_reg     <= '0;
                            state_reg <= GUARD;
                        end
                    end
                end
                GUARD: begin
                    if (step_in) begin
                        if (g_reg == GW'(GUARD_SAMPLES - 1)) begin
                            done_out  <= 1'b1;
                            state_reg <= IDLE;
                        end else begin
                            g_reg <= g_reg + 1'b1;
                        end
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ranging_burst_generator.sv
// Directed bench for ranging_burst_generator: expected samples are queued as each
// step is driven and compared once the DUT has registered them.
module tb_ranging_burst_generator;

    localparam int BS  = 48;
    localparam int HP  = 2;
    localparam int AMP = 12000;
    localparam int RL  = 3;
    localparam int GS  = 32;

    logic        clk_in = 1'b0;
    logic        rst_in;
    logic        step_in;
    logic        trigger_in;
    logic        abort_in;
    logic [15:0] amp_out;
    logic        start_out;
    logic        busy_out;
    logic        done_out;

    int checks = 0;
    int errors = 0;
    logic signed [15:0] exp_q[$];

    int spot_k[6] = '{0, 1, 2, 3, 8, 47};
    int spot_v[6] = '{1500, 3000, -4500, -6000, 12000, -1500};

    ranging_burst_generator #(
        .BURST_SAMPLES(BS),
        .HALF_PERIOD  (HP),
        .AMPLITUDE    (16'sd12000),
        .RAMP_LOG2    (RL),
        .GUARD_SAMPLES(GS)
    ) dut (
        .clk_in    (clk_in),
        .rst_in    (rst_in),
        .step_in   (step_in),
        .trigger_in(trigger_in),
        .abort_in  (abort_in),
        .amp_out   (amp_out),
        .start_out (start_out),
        .busy_out  (busy_out),
        .done_out  (done_out)
    );

    always #5 clk_in = ~clk_in;

    task automatic cyc();
        @(negedge clk_in);
    endtask

    task automatic check(input string tag, input logic signed [31:0] got,
                         input logic signed [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic logic signed [15:0] model_sample(input int k);
        int e;
        int mag;
        e = k + 1;
        if (BS - k < e) e = BS - k;
        if ((1 << RL) < e) e = 1 << RL;
        mag = (AMP * e) >> RL;
        return ((k / HP) % 2 == 0) ? 16'(mag) : 16'(-mag);
    endfunction

    task automatic gap(input int n, input logic signed [15:0] hold);
        repeat (n) begin
            cyc();
            check("hold_amp", $signed(amp_out), hold);
            check("hold_start", start_out, 1'b0);
            check("hold_done", done_out, 1'b0);
        end
    endtask

    task automatic step_sample(input int k);
        logic signed [15:0] e;
        exp_q.push_back(model_sample(k));
        step_in = 1'b1;
        cyc();
        step_in = 1'b0;
        e = exp_q.pop_front();
        $display("step k=%0d amp=%0d start=%0b", k, $signed(amp_out), start_out);
        check("sample_amp", $signed(amp_out), e);
        check("sample_start", start_out, (k == 0));
        for (int i = 0; i < 6; i++)
            if (spot_k[i] == k) check("spot_amp", $signed(amp_out), spot_v[i]);
        gap(3, e);
    endtask

    task automatic run_guard();
        for (int i = 0; i < GS; i++) begin
            step_in = 1'b1;
            cyc();
            step_in = 1'b0;
            check("guard_amp", $signed(amp_out), 0);
            check("guard_done", done_out, (i == GS - 1));
            check("guard_busy", busy_out, (i != GS - 1));
            check("guard_start", start_out, 1'b0);
            if (i != GS - 1) gap(3, 0);
        end
        $display("guard complete done=%0b busy=%0b", done_out, busy_out);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_in = 1'b1; step_in = 1'b0; trigger_in = 1'b0; abort_in = 1'b0;
        cyc(); cyc();
        check("rst_amp", $signed(amp_out), 0);
        check("rst_start", start_out, 1'b0);
        check("rst_busy", busy_out, 1'b0);
        check("rst_done", done_out, 1'b0);
        rst_in = 1'b0;
        cyc();

        // Full burst against the golden formula, then the end-of-burst step.
        trigger_in = 1'b1; cyc(); trigger_in = 1'b0;
        check("armed_busy", busy_out, 1'b1);
        check("armed_start", start_out, 1'b0);
        gap(2, 0);
        for (int k = 0; k < BS; k++) step_sample(k);
        step_in = 1'b1; cyc(); step_in = 1'b0;
        check("end_amp", $signed(amp_out), 0);
        check("end_busy", busy_out, 1'b1);
        check("end_done", done_out, 1'b0);
        gap(3, 0);

        // Trigger held through guard: no burst until back in IDLE.
        trigger_in = 1'b1;
        run_guard();
        cyc();
        check("done_width", done_out, 1'b0);
        check("rearm_busy", busy_out, 1'b1);
        check("rearm_start", start_out, 1'b0);
        trigger_in = 1'b0; abort_in = 1'b1; cyc(); abort_in = 1'b0;
        check("abort_armed_busy", busy_out, 1'b1);
        check("abort_armed_start", start_out, 1'b0);
        gap(3, 0);
        run_guard();
        cyc();
        check("idle_busy", busy_out, 1'b0);

        // Abort at k=10, colliding with a step.
        trigger_in = 1'b1; cyc(); trigger_in = 1'b0;
        for (int k = 0; k < 10; k++) step_sample(k);
        abort_in = 1'b1; step_in = 1'b1; cyc(); abort_in = 1'b0; step_in = 1'b0;
        check("abort_amp", $signed(amp_out), 0);
        check("abort_busy", busy_out, 1'b1);
        gap(3, 0);
        run_guard();
        cyc();
        check("abort_idle_busy", busy_out, 1'b0);

        // Trigger and step in the same clock.
        trigger_in = 1'b1; step_in = 1'b1; cyc(); trigger_in = 1'b0; step_in = 1'b0;
        check("same_clk_start", start_out, 1'b0);
        check("same_clk_busy", busy_out, 1'b1);
        check("same_clk_amp", $signed(amp_out), 0);
        gap(3, 0);
        step_sample(0);
        step_sample(1);
        abort_in = 1'b1; cyc(); abort_in = 1'b0;
        check("abort_burst_amp", $signed(amp_out), 0);
        run_guard();
        cyc();

        // Asynchronous reset mid-burst.
        trigger_in = 1'b1; cyc(); trigger_in = 1'b0;
        for (int k = 0; k < 5; k++) step_sample(k);
        #2 rst_in = 1'b1;
        #1;
        check("async_rst_amp", $signed(amp_out), 0);
        check("async_rst_busy", busy_out, 1'b0);
        cyc(); cyc();
        check("rst_no_done", done_out, 1'b0);
        rst_in = 1'b0;
        cyc();
        check("post_rst_busy", busy_out, 1'b0);
        trigger_in = 1'b1; cyc(); trigger_in = 1'b0;
        for (int k = 0; k < 3; k++) step_sample(k);
        abort_in = 1'b1; cyc(); abort_in = 1'b0;
        run_guard();
        cyc();
        check("final_busy", busy_out, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
